// File: rtl/hazard_detect_unit.sv
// Hazard detection for an in-order pipeline. It stalls ID on a load-use hazard or an ecall x17 dependency,
// drains the pipeline after a halting ecall, and counts stall cycles.
module hazard_detect_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_is_ecall,
  input  logic        id_halt_req,
  output logic        is_stall,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        is_halted,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } slot_t;

  localparam slot_t BUBBLE = '{valid: 1'b0, rd: 5'd0, reg_write: 1'b0, mem_read: 1'b0};
  localparam logic [4:0] ECALL_ARG_REG = 5'd17;

  state_t      state, state_next;
  logic [1:0]  drain_cnt, drain_cnt_next;
  slot_t       ex_slot, mem_slot, wb_slot;
  logic        load_use, ecall_dep, accept;

  assign load_use = ex_slot.valid && ex_slot.mem_read && (ex_slot.rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_slot.rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_slot.rd)));

  // The ecall reads x17 in ID, so an ALU producer in EX or a load still in MEM must be waited on.
  assign ecall_dep = id_is_ecall &&
                     ((ex_slot.valid && ex_slot.reg_write && (ex_slot.rd == ECALL_ARG_REG)) ||
                      (mem_slot.valid && mem_slot.mem_read && (mem_slot.rd == ECALL_ARG_REG)));

  assign is_stall   = (state == RUN) ? (id_valid && (load_use || ecall_dep)) : 1'b1;
  assign pc_write   = !is_stall;
  assign ifid_write = !is_stall;
  assign is_halted  = (state == HALTED);
  assign accept     = (state == RUN) && id_valid && !is_stall;

  // NOTE: every variable in an always_comb gets a default first; a path that leaves one unassigned
  // infers a latch.
  always_comb begin
    state_next     = state;
    drain_cnt_next = drain_cnt;
    unique case (state)
      RUN: begin
        if (accept && id_is_ecall && id_halt_req) begin
          state_next     = DRAIN;
          drain_cnt_next = 2'd3;
        end
      end
      DRAIN: begin
        drain_cnt_next = drain_cnt - 2'd1;
        if (drain_cnt == 2'd1) state_next = HALTED;
      end
      HALTED: state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values;
  // blocking here would let the slot shift read its own freshly written neighbour.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      drain_cnt <= 2'd0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_cnt_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_slot  <= BUBBLE;
      mem_slot <= BUBBLE;
      wb_slot  <= BUBBLE;
    end else begin
      wb_slot  <= mem_slot;
      mem_slot <= ex_slot;
      if (accept) begin
        ex_slot <= '{valid: 1'b1, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};
      end else begin
        ex_slot <= BUBBLE;
      end
    end
  end

  // Only RUN-state stalls are counted, so drain and halt cycles do not pollute the metric.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= 16'd0;
    end else if ((state == RUN) && is_stall && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Directed-vector bench for hazard_detect_unit. Inputs change 1 time unit after a rising edge,
// and outputs are sampled 1 time unit later.
module tb_hazard_detect_unit;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2;
  logic        id_reg_write, id_mem_read, id_is_ecall, id_halt_req;
  logic        is_stall, pc_write, ifid_write, is_halted;
  logic [15:0] stall_count;

  int n_checks = 0;
  int n_passed = 0;

  hazard_detect_unit dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .id_is_ecall  (id_is_ecall),
    .id_halt_req  (id_halt_req),
    .is_stall     (is_stall),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .is_halted    (is_halted),
    .stall_count  (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                        input logic u2, input logic [4:0] rd, input logic rw, input logic mr,
                        input logic ec, input logic hr);
    id_valid = v;   id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd;     id_reg_write = rw; id_mem_read = mr; id_is_ecall = ec; id_halt_req = hr;
    #1;
  endtask

  task automatic bubble();              set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic lw(input logic [4:0] rd, input logic [4:0] rs1);
    set_id(1, rs1, 1, 0, 0, rd, 1, 1, 0, 0);
  endtask
  task automatic alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2, input logic u2);
    set_id(1, rs1, 1, rs2, u2, rd, 1, 0, 0, 0);
  endtask
  task automatic ecall(input logic hr); set_id(1, 0, 0, 0, 0, 0, 0, 0, 1, hr); endtask

  task automatic flush();
    bubble();
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    bubble();
    #10;
    check("rst_stall",  is_stall,    0);
    check("rst_pcw",    pc_write,    1);
    check("rst_ifidw",  ifid_write,  1);
    check("rst_halted", is_halted,   0);
    check("rst_count",  stall_count, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // lw x5 ; add x6,x5,x7 -> one stall cycle
    lw(5, 1);
    check("lu_lw_nostall", is_stall, 0);
    tick();
    alu(6, 5, 7, 1);
    check("lu_stall", is_stall,   1);
    check("lu_pcw",   pc_write,   0);
    check("lu_ifidw", ifid_write, 0);
    tick();
    check("lu_count", stall_count, 1);
    check("lu_clear", is_stall,    0);
    tick();
    flush();

    // lw x0 then a use of x0: no hazard
    lw(0, 1);
    tick();
    alu(6, 0, 0, 1);
    check("x0_nohaz", is_stall, 0);
    tick();
    // lw x5 then an instruction that carries rs2=5 but does not read it
    lw(5, 1);
    tick();
    set_id(1, 3, 1, 5, 0, 8, 1, 0, 0, 0);
    check("rs2_unused_nohaz", is_stall, 0);
    tick();
    flush();
    check("nohaz_count", stall_count, 1);

    // addi x17 ; ecall -> one stall (EX match only)
    alu(17, 0, 0, 0);
    tick();
    ecall(0);
    check("ec_alu_stall", is_stall, 1);
    tick();
    check("ec_alu_clear", is_stall,    0);
    check("ec_alu_count", stall_count, 2);
    tick();
    flush();

    // lw x17 ; ecall -> two stalls (EX match, then MEM match)
    lw(17, 2);
    tick();
    ecall(0);
    check("ec_lw_stall_ex", is_stall, 1);
    tick();
    check("ec_lw_stall_mem", is_stall, 1);
    tick();
    check("ec_lw_clear", is_stall,    0);
    check("ec_lw_count", stall_count, 4);
    tick();
    flush();

    // load_use and ecall_dep together count a single stall per cycle
    lw(17, 2);
    tick();
    set_id(1, 17, 1, 0, 0, 0, 0, 0, 1, 0);
    check("both_stall", is_stall, 1);
    tick();
    check("both_count_once", stall_count, 5);
    check("both_mem_stall",  is_stall,    1);
    tick();
    check("both_count2", stall_count, 6);
    check("both_clear",  is_stall,    0);
    tick();
    flush();

    // Halting ecall that also looks like a load to x17, then reset in the 2nd DRAIN cycle
    set_id(1, 0, 0, 0, 0, 17, 1, 1, 1, 1);
    check("md_accept", is_stall, 0);
    tick();
    bubble();
    check("md_drain1_stall", is_stall, 1);
    tick();
    check("md_drain2_stall",  is_stall,    1);
    check("md_drain2_halted", is_halted,   0);
    check("md_drain2_count",  stall_count, 6);
    reset = 1'b1;
    ecall(0);
    check("md_rst_stall",  is_stall,    0);
    check("md_rst_pcw",    pc_write,    1);
    check("md_rst_halted", is_halted,   0);
    check("md_rst_count",  stall_count, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("md_slots_empty", is_stall, 0);
    tick();
    flush();

    // Full halt: one load-use stall first, then DRAIN x3 and HALTED
    lw(5, 1);
    tick();
    alu(6, 5, 7, 1);
    tick();
    tick();
    flush();
    check("halt_pre_count", stall_count, 1);
    ecall(1);
    check("halt_accept", is_stall, 0);
    tick();
    bubble();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("drain%0d_stall", i), is_stall, 1);
      check($sformatf("drain%0d_halted", i), is_halted, 0);
      tick();
    end
    check("halted_pcw", pc_write, 0);
    alu(6, 5, 7, 1);
    for (int i = 0; i < 22; i++) begin
      check($sformatf("halted%0d", i), {is_halted, is_stall, stall_count}, {1'b1, 1'b1, 16'd1});
      tick();
    end

    // Saturation: a fake ecall writing x17 from memory stalls twice every three cycles
    reset = 1'b1;
    bubble();
    @(negedge clk);
    reset = 1'b0;
    tick();
    set_id(1, 0, 0, 0, 0, 17, 1, 1, 1, 0);
    repeat (3) tick();
    check("sat_first_period", stall_count, 2);
    repeat (98301 - 3) tick();
    check("sat_fffe", stall_count, 16'hFFFE);
    repeat (3) tick();
    check("sat_ffff", stall_count, 16'hFFFF);
    repeat (6) tick();
    check("sat_hold", stall_count, 16'hFFFF);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
